// File: rtl/entropy_pool_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// entropy_pkg
// Shared types and sizing helpers for the entropy pool arbiter.
//   state_t      : arbiter FSM states (IDLE, FILL, GRANT)
//   clog2_min1() : pointer width that stays at least 1 bit for tiny counts
//   fresh_width(): width of the saturating fresh-bit counter (must hold
//                  the value POOL_BITS itself, hence the extra bit)
// ----------------------------------------------------------------------------
package entropy_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      GRANT = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int fresh_width(input int pool_bits);
      return $clog2(pool_bits) + 1;
   endfunction

endpackage

// File: rtl/entropy_pool_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first asserted
// request at or after ptr, searching upward and wrapping.
//   req : per-requester request levels
//   ptr : highest-priority index for this pick (0..N-1)
//   win : one-hot winner (all zero when no request)
//   any : at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter
   import entropy_pkg::*;
#(
   parameter int N = 2,
   localparam int PW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic          any
);

   int w_idx;

   always_comb begin
      win   = '0;
      any   = 1'b0;
      w_idx = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(ptr) + k) % N;
         if (!any && req[w_idx]) begin
            win[w_idx] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/entropy_pool_arbiter.sv
// ----------------------------------------------------------------------------
// entropy_pool_arbiter
// Folds one parity bit per audio sample strobe into a circular pool and hands
// a full snapshot of the pool to one requester at a time, round-robin, once
// enough fresh bits have been accumulated.
//   clock, reset  : system clock, asynchronous active-high reset
//   sample        : audio sample; its XOR parity is the harvested bit
//   sample_ready  : level strobe; only its rising edge harvests a bit
//   enable        : low freezes accumulation and blocks grants
//   req           : per-requester request level, held until granted
//   grant         : one-hot, one-cycle grant pulse
//   rand_valid    : high together with grant
//   rand_data     : pool snapshot, held until the next grant
//   fresh_count   : saturating count of bits folded in since last delivery
//   pool_ready    : fresh_count >= MIN_FRESH
// Valid/ready: a requester raises req and holds it; the block answers with a
// single-cycle grant bit plus rand_valid, and rand_data is valid that cycle.
// ----------------------------------------------------------------------------
module entropy_pool_arbiter
   import entropy_pkg::*;
#(
   parameter int WIDTH     = 9,
   parameter int POOL_BITS = 256,
   parameter int NUM_REQ   = 2,
   parameter int MIN_FRESH = 256,
   localparam int FRESH_W  = fresh_width(POOL_BITS)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     sample,
   input  logic                 sample_ready,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 rand_valid,
   output logic [POOL_BITS-1:0] rand_data,
   output logic [FRESH_W-1:0]   fresh_count,
   output logic                 pool_ready
);

   localparam int PTR_W = $clog2(POOL_BITS);
   localparam int RR_W  = clog2_min1(NUM_REQ);

   state_t               r_state;
   logic                 r_old_ready;
   logic                 r_edge;
   logic                 r_par;
   logic [POOL_BITS-1:0] r_pool;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [FRESH_W-1:0]   r_fresh;
   logic [RR_W-1:0]      r_rr_ptr;
   logic [NUM_REQ-1:0]   r_grant;
   logic                 r_valid;
   logic [POOL_BITS-1:0] r_data;

   logic [NUM_REQ-1:0]   w_win;
   logic                 w_any;
   logic [RR_W-1:0]      w_next_rr;
   logic                 w_accept;
   logic                 w_do_grant;
   logic                 w_pool_ready;
   logic [FRESH_W-1:0]   w_fresh_inc;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req (req),
      .ptr (r_rr_ptr),
      .win (w_win),
      .any (w_any)
   );

   // Pointer for the next pick is one past the winner, wrapping.
   always_comb begin
      w_next_rr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win[k]) begin
            w_next_rr = (k == NUM_REQ - 1) ? '0 : RR_W'(k + 1);
         end
      end
   end

   // An edge registered last cycle is only harvested while running.
   assign w_accept     = r_edge & enable & (r_state != IDLE);
   assign w_pool_ready = (r_fresh >= FRESH_W'(MIN_FRESH));
   assign w_do_grant   = (r_state == FILL) & enable & w_pool_ready & w_any;
   assign w_fresh_inc  = (r_fresh == FRESH_W'(POOL_BITS)) ? r_fresh
                                                          : r_fresh + FRESH_W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         // Starts high so a strobe already high at release is not an edge.
         r_old_ready <= 1'b1;
         r_edge      <= 1'b0;
         r_par       <= 1'b0;
         r_pool      <= '0;
         r_wr_ptr    <= '0;
         r_fresh     <= '0;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
      end else begin
         r_old_ready <= sample_ready;
         r_edge      <= sample_ready & ~r_old_ready;
         r_par       <= ^sample;

         if (w_accept) begin
            r_pool[r_wr_ptr] <= r_pool[r_wr_ptr] ^ r_par;
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
         end

         // A bit harvested on the grant edge counts toward the next delivery.
         if (w_do_grant) begin
            r_fresh <= w_accept ? FRESH_W'(1) : '0;
         end else if (w_accept) begin
            r_fresh <= w_fresh_inc;
         end

         case (r_state)
            IDLE: begin
               r_grant <= '0;
               r_valid <= 1'b0;
               if (enable) r_state <= FILL;
            end
            FILL: begin
               if (!enable) begin
                  r_state <= IDLE;
               end else if (w_do_grant) begin
                  r_state  <= GRANT;
                  r_grant  <= w_win;
                  r_valid  <= 1'b1;
                  r_data   <= r_pool;
                  r_rr_ptr <= w_next_rr;
               end
            end
            GRANT: begin
               r_grant <= '0;
               r_valid <= 1'b0;
               r_state <= enable ? FILL : IDLE;
            end
            default: begin
               r_grant <= '0;
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign rand_valid  = r_valid;
   assign rand_data   = r_data;
   assign fresh_count = r_fresh;
   assign pool_ready  = w_pool_ready;

endmodule

// File: tb/tb_entropy_pool_arbiter.sv
// ----------------------------------------------------------------------------
// tb_entropy_pool_arbiter
// Self-checking bench for entropy_pool_arbiter with an 8-bit pool.
// Expected grants ({grant, rand_data}) are queued when the stimulus that
// causes them is driven and popped when rand_valid appears.
// ----------------------------------------------------------------------------
module tb_entropy_pool_arbiter;

   localparam int WIDTH     = 9;
   localparam int POOL_BITS = 8;
   localparam int NUM_REQ   = 2;
   localparam int MIN_FRESH = 8;
   localparam int FRESH_W   = $clog2(POOL_BITS) + 1;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [WIDTH-1:0]     sample = '0;
   logic                 sample_ready = 1'b1;
   logic                 enable = 1'b0;
   logic [NUM_REQ-1:0]   req = '0;
   logic [NUM_REQ-1:0]   grant;
   logic                 rand_valid;
   logic [POOL_BITS-1:0] rand_data;
   logic [FRESH_W-1:0]   fresh_count;
   logic                 pool_ready;

   int n_checks = 0;
   int n_errors = 0;
   int n_grants = 0;

   logic [9:0]  exp_q[$];
   logic [9:0]  mon_e;
   logic [7:0]  m_pool;
   int          m_wr;
   logic [7:0]  last_data = '0;
   logic [7:0]  e_data;
   logic [7:0]  t2_par = 8'b01001101;

   entropy_pool_arbiter #(
      .WIDTH     (WIDTH),
      .POOL_BITS (POOL_BITS),
      .NUM_REQ   (NUM_REQ),
      .MIN_FRESH (MIN_FRESH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .sample       (sample),
      .sample_ready (sample_ready),
      .enable       (enable),
      .req          (req),
      .grant        (grant),
      .rand_valid   (rand_valid),
      .rand_data    (rand_data),
      .fresh_count  (fresh_count),
      .pool_ready   (pool_ready)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: compare each delivered grant with the oldest expectation
   always @(negedge clock) begin
      if (!reset && rand_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_grant", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            check("grant", {30'd0, grant}, {30'd0, mon_e[9:8]});
            check("rand_data", {24'd0, rand_data}, {24'd0, mon_e[7:0]});
            last_data = mon_e[7:0];
         end
         n_grants++;
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One strobe pulse (high one cycle, low after). req and enable take their
   // new values on the falling edge of the strobe, i.e. in the cycle the
   // registered edge is evaluated. accept says whether the model folds it in.
   task automatic sample_pulse(input logic p, input logic [1:0] new_req,
                               input logic new_en, input logic accept);
      logic [WIDTH-1:0] s;
      @(negedge clock);
      s = WIDTH'($urandom_range(0, 511));
      if ((^s) != p) s[0] = ~s[0];
      sample       = s;
      sample_ready = 1'b1;
      @(negedge clock);
      sample_ready = 1'b0;
      req          = new_req;
      enable       = new_en;
      sample       = WIDTH'($urandom_range(0, 511));
      if (accept) begin
         m_pool[m_wr] = m_pool[m_wr] ^ p;
         m_wr = (m_wr + 1) % POOL_BITS;
      end
   endtask

   // Returns #1 after the negedge on which grant number target was seen.
   task automatic wait_grants(input int target, input int budget);
      int c = 0;
      while (n_grants < target && c < budget) begin
         @(negedge clock);
         #1;
         c++;
      end
      check("grant_seen", (n_grants >= target), 1);
   endtask

   initial begin
      m_pool = '0;
      m_wr   = 0;

      // reset state, strobe held high through release
      idle(3);
      check("rst_grant", {30'd0, grant}, 0);
      check("rst_valid", {31'd0, rand_valid}, 0);
      check("rst_data", {24'd0, rand_data}, 0);
      check("rst_fresh", {28'd0, fresh_count}, 0);
      check("rst_pool_ready", {31'd0, pool_ready}, 0);
      enable = 1'b1;
      reset  = 1'b0;
      idle(3);
      check("release_fresh", {28'd0, fresh_count}, 0);
      check("release_valid", {31'd0, rand_valid}, 0);
      sample_ready = 1'b0;
      idle(1);

      // first fill, single requester
      req = 2'b01;
      for (int i = 0; i < 8; i++) begin
         sample_pulse(t2_par[i], 2'b01, 1'b1, 1'b1);
         if (i == 0) begin
            check("fresh_latency", {28'd0, fresh_count}, 0);
            idle(1);
            check("fresh_first", {28'd0, fresh_count}, 1);
         end
      end
      exp_q.push_back({2'b01, m_pool});
      idle(1);
      check("fresh_full", {28'd0, fresh_count}, 8);
      check("pool_ready_full", {31'd0, pool_ready}, 1);
      wait_grants(1, 20);
      req = 2'b00;
      check("fresh_after_grant", {28'd0, fresh_count}, 0);
      idle(1);
      check("pulse_end_grant", {30'd0, grant}, 0);
      check("pulse_end_valid", {31'd0, rand_valid}, 0);
      check("data_hold", {24'd0, rand_data}, {24'd0, last_data});

      // second fill, both requesting: round-robin moves to requester 1
      for (int i = 0; i < 8; i++) sample_pulse(1'b1, 2'b11, 1'b1, 1'b1);
      exp_q.push_back({2'b10, m_pool});
      wait_grants(2, 20);
      req = 2'b00;

      // third fill; request raised so the grant edge also harvests a bit
      for (int i = 0; i < 8; i++) sample_pulse(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b1);
      idle(2);
      check("fresh_no_req", {28'd0, fresh_count}, 8);
      check("no_grant_no_req", n_grants, 2);
      e_data = m_pool;
      sample_pulse(1'b1, 2'b11, 1'b1, 1'b1);
      exp_q.push_back({2'b01, e_data});
      wait_grants(3, 20);
      req = 2'b00;
      check("fresh_coincident", {28'd0, fresh_count}, 1);

      // enable dropped at five fresh bits, three strobes while disabled
      for (int i = 0; i < 4; i++) sample_pulse(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b1);
      idle(1);
      check("fresh_five", {28'd0, fresh_count}, 5);
      sample_pulse(1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) sample_pulse(1'($urandom_range(0, 1)), 2'b01, 1'b0, 1'b0);
      idle(2);
      check("fresh_frozen", {28'd0, fresh_count}, 5);
      check("pool_ready_frozen", {31'd0, pool_ready}, 0);
      check("no_grant_disabled", n_grants, 3);
      enable = 1'b1;
      idle(2);
      for (int i = 0; i < 2; i++) sample_pulse(1'($urandom_range(0, 1)), 2'b01, 1'b1, 1'b1);
      idle(2);
      check("fresh_seven", {28'd0, fresh_count}, 7);
      check("no_grant_seven", n_grants, 3);
      sample_pulse(1'($urandom_range(0, 1)), 2'b01, 1'b1, 1'b1);
      exp_q.push_back({2'b01, m_pool});
      wait_grants(4, 20);
      req = 2'b00;

      // asynchronous reset inside the grant cycle
      for (int i = 0; i < 8; i++) sample_pulse(1'($urandom_range(0, 1)), 2'b10, 1'b1, 1'b1);
      exp_q.push_back({2'b10, m_pool});
      wait_grants(5, 20);
      check("grant_live", {31'd0, rand_valid}, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_grant", {30'd0, grant}, 0);
      check("async_valid", {31'd0, rand_valid}, 0);
      check("async_data", {24'd0, rand_data}, 0);
      check("async_fresh", {28'd0, fresh_count}, 0);
      check("async_pool_ready", {31'd0, pool_ready}, 0);
      req = 2'b00;
      idle(2);
      reset = 1'b0;
      idle(3);
      check("post_reset_fresh", {28'd0, fresh_count}, 0);
      check("post_reset_valid", {31'd0, rand_valid}, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/entropy_pool_arbiter.md
Name: entropy_pool_arbiter

Overview:
Owns the audio-parity entropy pool and shares it between several consumers, such as the key-exchange and nonce generators.
- On each rising edge of the codec sample strobe, XOR-folds one parity bit of the sample into a circular POOL_BITS-bit pool.
- Counts fresh bits since the last delivery.
- Once enough fresh bits exist, grants one snapshot of the pool to a single requester, chosen by round-robin.
- Sits between the AC97 capture path and the crypto/protocol blocks.

Parameters:
WIDTH, 9, audio sample width.
POOL_BITS, 256, pool size in bits; power of two, at least 2.
NUM_REQ, 2, number of requesters; at least 1.
MIN_FRESH, 256, fresh bits required before a grant; range 1..POOL_BITS.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
sample  in  WIDTH  audio sample from the AC97 path.
sample_ready  in  1  level strobe from the AC97 path; only the rising edge is used.
enable  in  1  when low, freezes accumulation and blocks grants.
req  in  NUM_REQ  per-requester request level, held until granted.
grant  out  NUM_REQ  one-hot, one-cycle pulse.
rand_valid  out  1  high in the same cycle as grant.
rand_data  out  POOL_BITS  pool snapshot delivered with the grant.
fresh_count  out  clog2(POOL_BITS)+1  fresh bits accumulated, saturating.
pool_ready  out  1  high when fresh_count >= MIN_FRESH.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - pool=0, wr_ptr=0, fresh_count=0, rr_ptr=0, state=IDLE.
  - grant=0, rand_valid=0, rand_data=0, pool_ready=0.
  - old_ready=1, so a strobe that is high at reset release is not counted.
  - Reset mid-grant or mid-fill discards everything; no partial outputs.
- Sample edge: edge = sample_ready & ~old_ready, registered every cycle.
  - Edge is acted on only when enable=1 and state!=IDLE.
  - On an accepted edge: pool[wr_ptr] <= pool[wr_ptr] ^ (^sample); wr_ptr <= wr_ptr+1, wrapping mod POOL_BITS.
  - fresh_count <= min(fresh_count+1, POOL_BITS).
- pool_ready is combinational from fresh_count.
- States:
  - IDLE: entered on reset. Go to FILL when enable=1.
  - FILL: accumulate samples.
    - If enable=0: go to IDLE; pool and fresh_count are retained.
    - If pool_ready and |req at clock edge E: go to GRANT.
      - At E: grant <= one-hot of the winner, rand_valid <= 1.
      - rand_data <= pool value before any update at E.
      - fresh_count <= 1 if an edge is accepted at E, else 0.
      - rr_ptr <= winner+1 mod NUM_REQ.
  - GRANT: lasts exactly one cycle.
    - grant and rand_valid are high in this state.
    - Next edge: grant=0, rand_valid=0; go to FILL, or to IDLE if enable=0.
    - Samples arriving in GRANT are accumulated normally.
- Round-robin arbitration:
  - Winner is the first asserted req at or after rr_ptr, searching upward with wrap.
  - With a single requester, that requester always wins.
- rand_data holds its last delivered value until the next grant.
- A req dropped before being granted is simply not served.
- No back-to-back grants: fresh_count <= 1 after a grant and MIN_FRESH >= 1, so GRANT is never re-entered within MIN_FRESH edges (only once MIN_FRESH new edges have been accepted).
- enable falling during FILL:
  - Any sample edge in that same cycle is ignored.
  - fresh_count and pool are retained for the next FILL.
- Latency:
  - Sample edge at the input to pool update: 2 cycles (edge-detect register, then pool write).
  - req with pool_ready to grant: 1 cycle.

Decomposition:
- Package entropy_pkg:
  - state enum {IDLE, FILL, GRANT}.
  - Helper for clog2(POOL_BITS) and the fresh_count width.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot win[N], any.
  - Purely combinational.
- Pool, pointers and FSM stay in the top module.

Test Plan:
1. Reset release with sample_ready=1 held high, POOL_BITS=8, MIN_FRESH=8 -> no pool write, fresh_count=0, all outputs 0.
2. enable=1; 8 strobe edges with samples of parity 1,0,1,1,0,0,1,0 (bit0 first); req=01 held -> fresh_count reaches 8, pool_ready=1.
   - Next edge: grant=01, rand_valid=1 for exactly one cycle, rand_data=8'b01001101.
   - Then fresh_count=0.
3. Continue with 8 more edges of parity 1, so each bit XORs with 1; req=11 -> grant=10 (round-robin after 01), rand_data=8'b10110010.
   - Next fill with req=11 -> grant=01.
4. Sample edge in the same cycle the grant is issued -> rand_data excludes that bit, fresh_count=1 afterwards, pool includes the bit.
5. enable dropped after 5 edges, 3 further edges applied, then enable raised -> fresh_count stays 5 while disabled.
   - No grant until 3 more enabled edges arrive.
6. Assert reset asynchronously in the GRANT cycle -> grant, rand_valid and rand_data go to 0 immediately, without waiting for a clock edge; fresh_count=0.
